layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed width of neuron values and weights.
REQ-002 SHALL have parameter ADDR_W, default 8, width of all memory addresses.
REQ-003 SHALL have parameter ACC_W, default 24, signed accumulator width.
REQ-004 SHALL have parameter FRAC, default 0, right-shift applied to the accumulator before activation.
REQ-005 SHALL have parameters PING_BASE, default 0, and PONG_BASE, default 128, the neuron-bank base addresses.
REQ-006 SHALL have parameter WEIGHT_BASE, default 0, the first weight address.
REQ-007 SHALL use one clock and a synchronous, active-high reset; ports clk and reset.
REQ-008 SHALL have these ports, one per line:
 clk  in  1  clock, rising edge
 reset  in  1  synchronous active-high reset
 start  in  1  begin network evaluation, sampled in IDLE only
 num_layers  in  4  computed layers L, 1..15
 cfg_idx  out  4  layer-size table index
 cfg_size  in  ADDR_W  combinational size of entry cfg_idx (index 0 = input layer)
 w_addr  out  ADDR_W  weight ROM address
 w_data  in  DATA_W  weight, valid one cycle after w_addr
 rd_addr  out  ADDR_W  neuron RAM read address
 rd_data  in  DATA_W  neuron value, valid one cycle after rd_addr
 wr_en  out  1  neuron RAM write strobe
 wr_addr  out  ADDR_W  neuron RAM write address
 wr_data  out  DATA_W  activated neuron value
 busy  out  1  high from the cycle after an accepted start until done
 done  out  1  one-cycle completion pulse
 err  out  1  one-cycle pulse on zero-sized layer abort
 result_base  out  ADDR_W  bank base holding the final layer outputs

Function
REQ-009 SHALL implement states IDLE, CFG, MAC, DRAIN, WRITE, DONE.
REQ-010 IDLE: cfg_idx=0; on start, SHALL latch Nin=cfg_size, layer=1, in_base=PING_BASE, out_base=PONG_BASE, w_addr=WEIGHT_BASE, then go to CFG.
REQ-011 CFG: cfg_idx=layer; SHALL latch Nout=cfg_size, clear neuron index j and input index k, clear the accumulator, then go to MAC.
REQ-012 CFG: if Nin=0 or Nout=0, SHALL pulse err, write nothing and return to IDLE; num_layers=0 at start SHALL behave identically.
REQ-013 MAC: each cycle SHALL drive rd_addr=in_base+k and w_addr as the current weight address, then increment k and w_addr; after issuing k=Nin-1, go to DRAIN.
REQ-014 Each cycle following an issue cycle, SHALL accumulate acc += signed(rd_data)*signed(w_data), sign-extended to ACC_W; overflow wraps modulo 2^ACC_W.
REQ-015 DRAIN: SHALL accumulate the final product and go to WRITE.
REQ-016 WRITE: SHALL assert wr_en for one cycle with wr_addr=out_base+j and wr_data=clamp(max(acc>>>FRAC,0), 0, 2^(DATA_W-1)-1).
REQ-017 After WRITE: if j<Nout-1, SHALL increment j, clear k and acc, and go to MAC; else if layer<num_layers, SHALL set Nin=Nout, increment layer, swap in_base/out_base and go to CFG; else go to DONE.
REQ-018 w_addr SHALL advance continuously across neurons and layers (row-major, no reset per layer); all address arithmetic wraps modulo 2^ADDR_W.
REQ-019 Per-neuron latency SHALL be Nin+2 cycles; start-to-done latency SHALL be 1 + sum over layers of (1 + Nout*(Nin+2)) cycles, with done in the final cycle.
REQ-020 DONE: SHALL pulse done, set result_base to the last out_base, and return to IDLE.
REQ-021 start outside IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-022 wr_en SHALL be low in every state except WRITE.

Reset
REQ-023 Reset SHALL force IDLE, busy=0, done=0, err=0, wr_en=0, cfg_idx=0, w_addr=WEIGHT_BASE, rd_addr=PING_BASE, wr_addr=PONG_BASE, wr_data=0, result_base=PING_BASE, and acc=0.
REQ-024 Reset asserted mid-operation SHALL take effect on the same edge, suppressing any pending write and done.

Verification
REQ-025 sizes [2,1], L=1, x=[3,4] at 0..1, w=[2,5] -> single write addr 128 data 26; done 6 cycles after start; result_base=128.
REQ-026 sizes [2,2,1], L=2, x=[1,1], w=[1,2,3,4,1,-1] -> writes 128=3, 129=7, then 0=0 (ReLU of -4); result_base=0.
REQ-027 sizes [2,1], x=[100,100], w=[1,1] -> wr_data=127 (saturation); w=[-1,-1] -> wr_data=0.
REQ-028 cfg_size[1]=0 -> err pulse in cycle 2, no wr_en, busy low after, no done.
REQ-029 reset asserted during MAC of the 2nd neuron of REQ-026 -> no further wr_en; all outputs at reset values next cycle; a new start reruns correctly.
REQ-030 start held high continuously through a run -> only one evaluation until IDLE; w_addr restarts at WEIGHT_BASE on the next accepted start.

Source files
------------

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : layer_sequencer
//  Purpose  : Sequences a fully-connected ReLU network layer by layer, doing
//             one MAC per cycle over ping/pong neuron banks and a weight ROM.
//  Revision : 1.0  initial release
// ============================================================================
module layer_sequencer #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int ACC_W       = 24,
    parameter int FRAC        = 0,
    parameter int PING_BASE   = 0,
    parameter int PONG_BASE   = 128,
    parameter int WEIGHT_BASE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        num_layers,
    output logic [3:0]        cfg_idx,
    input  logic [ADDR_W-1:0] cfg_size,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] result_base
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0]       c_ping    = ADDR_W'(PING_BASE);
    localparam logic [ADDR_W-1:0]       c_pong    = ADDR_W'(PONG_BASE);
    localparam logic [ADDR_W-1:0]       c_wbase   = ADDR_W'(WEIGHT_BASE);
    localparam logic [ADDR_W-1:0]       c_one     = ADDR_W'(1);
    localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'((2 ** (DATA_W - 1)) - 1);

    state_t                   r_state;
    logic [ADDR_W-1:0]        r_nin;
    logic [ADDR_W-1:0]        r_nout;
    logic [ADDR_W-1:0]        r_j;
    logic [ADDR_W-1:0]        r_k;
    logic [ADDR_W-1:0]        r_in_base;
    logic [ADDR_W-1:0]        r_out_base;
    logic [3:0]               r_layer;
    logic [3:0]               r_num_layers;
    logic signed [ACC_W-1:0]  r_acc;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_acc_sum;
    logic signed [ACC_W-1:0]    w_shifted;
    logic [DATA_W-1:0]          w_act;

    assign w_prod     = $signed(rd_data) * $signed(w_data);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_acc_sum  = r_acc + w_prod_ext;
    assign w_shifted  = w_acc_sum >>> FRAC;

    // ReLU followed by saturation to the positive range of DATA_W
    always_comb begin
        w_act = w_shifted[DATA_W-1:0];
        if (w_shifted[ACC_W-1]) begin
            w_act = '0;
        end else if (w_shifted > c_sat_max) begin
            w_act = c_sat_max[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            wr_en        <= 1'b0;
            cfg_idx      <= 4'd0;
            w_addr       <= c_wbase;
            rd_addr      <= c_ping;
            wr_addr      <= c_pong;
            wr_data      <= '0;
            result_base  <= c_ping;
            r_acc        <= '0;
            r_nin        <= '0;
            r_nout       <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_in_base    <= c_ping;
            r_out_base   <= c_pong;
            r_layer      <= 4'd0;
            r_num_layers <= 4'd0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    cfg_idx <= 4'd0;
                    if (start) begin
                        r_nin        <= cfg_size;
                        r_num_layers <= num_layers;
                        r_layer      <= 4'd1;
                        r_in_base    <= c_ping;
                        r_out_base   <= c_pong;
                        w_addr       <= c_wbase;
                        cfg_idx      <= 4'd1;
                        busy         <= 1'b1;
                        r_state      <= S_CFG;
                    end
                end
                S_CFG: begin
                    r_nout  <= cfg_size;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_acc   <= '0;
                    rd_addr <= r_in_base;
                    if (r_nin == '0 || cfg_size == '0 || r_num_layers == 4'd0) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        cfg_idx <= 4'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Operands issued in the previous cycle are valid now
                    if (r_k != '0) begin
                        r_acc <= w_acc_sum;
                    end
                    r_k     <= r_k + c_one;
                    w_addr  <= w_addr + c_one;
                    rd_addr <= rd_addr + c_one;
                    if (r_k == r_nin - c_one) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_acc   <= w_acc_sum;
                    wr_en   <= 1'b1;
                    wr_addr <= r_out_base + r_j;
                    wr_data <= w_act;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_j != r_nout - c_one) begin
                        r_j     <= r_j + c_one;
                        r_k     <= '0;
                        r_acc   <= '0;
                        rd_addr <= r_in_base;
                        r_state <= S_MAC;
                    end else if (r_layer < r_num_layers) begin
                        r_nin      <= r_nout;
                        r_layer    <= r_layer + 4'd1;
                        cfg_idx    <= r_layer + 4'd1;
                        r_in_base  <= r_out_base;
                        r_out_base <= r_in_base;
                        r_state    <= S_CFG;
                    end else begin
                        done        <= 1'b1;
                        result_base <= r_out_base;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    cfg_idx <= 4'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_sequencer
//  Purpose  : Directed, table-driven bench for layer_sequencer with ROM/RAM
//             models and hand-written reset / held-start sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_layers;
    logic [3:0] cfg_idx;
    logic [7:0] cfg_size;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result_base;

    layer_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_layers  (num_layers),
        .cfg_idx     (cfg_idx),
        .cfg_size    (cfg_size),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .result_base (result_base)
    );

    always #5 clk = ~clk;

    logic [7:0] sizes [16];
    logic [7:0] wrom  [256];
    logic [7:0] ram   [256];
    logic       load;
    int         ld_x0;
    int         ld_x1;

    assign cfg_size = sizes[cfg_idx];

    // Registered ROM/RAM models; the load strobe re-seeds the input bank
    always @(posedge clk) begin
        w_data  <= wrom[w_addr];
        rd_data <= ram[rd_addr];
        if (load) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'd0;
            ram[0] <= 8'(ld_x0);
            ram[1] <= 8'(ld_x1);
        end else if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    typedef struct {
        int s0, s1, s2, s3;
        int l;
        int x0, x1;
        int w0, w1, w2, w3, w4, w5;
        int e, lat, nw;
        int wa0, wd0, wa1, wd1, wa2, wd2;
        int rb;
    } vec_t;

    vec_t vecs [9];
    int   errors = 0;
    int   checks = 0;
    int   wlog_a [8];
    int   wlog_d [8];
    int   nwr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 16; i++) sizes[i] = 8'd0;
        sizes[0] = 8'(v.s0); sizes[1] = 8'(v.s1);
        sizes[2] = 8'(v.s2); sizes[3] = 8'(v.s3);
        for (int i = 0; i < 256; i++) wrom[i] = 8'd0;
        wrom[0] = 8'(v.w0); wrom[1] = 8'(v.w1); wrom[2] = 8'(v.w2);
        wrom[3] = 8'(v.w3); wrom[4] = 8'(v.w4); wrom[5] = 8'(v.w5);
        ld_x0 = v.x0;
        ld_x1 = v.x1;
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        num_layers = 4'(v.l);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        bit   got_done;
        bit   got_err;
        v = vecs[idx];
        load_vec(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nwr = 0; lat = 0; got_done = 0; got_err = 0;
        for (int i = 0; i < 8; i++) begin wlog_a[i] = -1; wlog_d[i] = -1; end
        for (int c = 1; c <= 400; c++) begin
            if (wr_en) begin
                if (nwr < 8) begin wlog_a[nwr] = wr_addr; wlog_d[nwr] = wr_data; end
                nwr++;
            end
            if (done || err) begin
                lat = c; got_done = done; got_err = err;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: got no done/err, required one within 400 cycles", idx);
        end
        chk($sformatf("v%0d_err", idx), int'(got_err), v.e);
        chk($sformatf("v%0d_done", idx), int'(got_done), 1 - v.e);
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_nwrites", idx), nwr, v.nw);
        if (v.nw >= 1) begin
            chk($sformatf("v%0d_wa0", idx), wlog_a[0], v.wa0);
            chk($sformatf("v%0d_wd0", idx), wlog_d[0], v.wd0);
        end
        if (v.nw >= 2) begin
            chk($sformatf("v%0d_wa1", idx), wlog_a[1], v.wa1);
            chk($sformatf("v%0d_wd1", idx), wlog_d[1], v.wd1);
        end
        if (v.nw >= 3) begin
            chk($sformatf("v%0d_wa2", idx), wlog_a[2], v.wa2);
            chk($sformatf("v%0d_wd2", idx), wlog_d[2], v.wd2);
        end
        if (v.e == 0) chk($sformatf("v%0d_result_base", idx), int'(result_base), v.rb);
        @(negedge clk);
        chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
        chk($sformatf("v%0d_done_after", idx), int'(done), 0);
        chk($sformatf("v%0d_err_after", idx), int'(err), 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_cfg_idx"}, int'(cfg_idx), 0);
        chk({tag, "_w_addr"}, int'(w_addr), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 128);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_result_base"}, int'(result_base), 0);
    endtask

    initial begin
        int n_done;
        int n_wr;
        bit seen;

        //        s0 s1 s2 s3  L  x0    x1    w0    w1   w2 w3 w4 w5  e lat nw  wa0 wd0 wa1 wd1 wa2 wd2  rb
        vecs[0] = '{2, 1, 0, 0, 1, 3,    4,    2,    5,   0, 0, 0, 0,  0, 6,  1, 128, 26,  0,  0,  0,  0, 128};
        vecs[1] = '{2, 2, 1, 0, 2, 1,    1,    1,    2,   3, 4, 1, -1, 0, 15, 3, 128, 3, 129,  7,  0,  0, 0};
        vecs[2] = '{2, 1, 0, 0, 1, 100,  100,  1,    1,   0, 0, 0, 0,  0, 6,  1, 128, 127, 0,  0,  0,  0, 128};
        vecs[3] = '{2, 1, 0, 0, 1, 100,  100,  -1,   -1,  0, 0, 0, 0,  0, 6,  1, 128, 0,   0,  0,  0,  0, 128};
        vecs[4] = '{2, 0, 0, 0, 1, 1,    1,    1,    1,   0, 0, 0, 0,  1, 2,  0, 0,   0,   0,  0,  0,  0, 0};
        vecs[5] = '{2, 1, 0, 0, 0, 1,    1,    1,    1,   0, 0, 0, 0,  1, 2,  0, 0,   0,   0,  0,  0,  0, 0};
        vecs[6] = '{1, 3, 0, 0, 1, -5,   0,    2,    -3,  0, 0, 0, 0,  0, 11, 3, 128, 0, 129, 15, 130,  0, 128};
        vecs[7] = '{2, 1, 0, 0, 1, -128, -128, -128, -128, 0, 0, 0, 0, 0, 6,  1, 128, 127, 0,  0,  0,  0, 128};
        vecs[8] = '{1, 1, 1, 1, 3, 2,    0,    3,    2,   5, 0, 0, 0,  0, 13, 3, 128, 6,   0, 12, 128, 60, 128};

        reset = 1'b1; start = 1'b0; load = 1'b0; num_layers = 4'd0;
        ld_x0 = 0; ld_x1 = 0;
        for (int i = 0; i < 16; i++) sizes[i] = 8'd0;
        for (int i = 0; i < 256; i++) wrom[i] = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_values("reset");

        for (int i = 0; i < 9; i++) run_vec(i);

        // Reset during MAC of the second neuron of the two-layer network
        load_vec(vecs[1]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_wr = 0;
        for (int c = 1; c <= 6; c++) begin
            if (wr_en) begin
                n_wr++;
                chk("midrst_first_wr_data", int'(wr_data), 3);
            end
            if (c < 6) @(negedge clk);
        end
        chk("midrst_writes_before", n_wr, 1);
        chk("midrst_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_values("midrst");
        reset = 1'b0;
        n_wr = 0; n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (wr_en) n_wr++;
            if (done) n_done++;
        end
        chk("midrst_writes_after", n_wr, 0);
        chk("midrst_done_after", n_done, 0);
        run_vec(1);

        // Start held high: exactly one evaluation, then a fresh one from WEIGHT_BASE
        load_vec(vecs[0]);
        start = 1'b1;
        @(negedge clk);
        n_done = 0; n_wr = 0;
        for (int c = 1; c <= 7; c++) begin
            if (done) begin
                n_done++;
                chk("held_done_cycle", c, 6);
            end
            if (wr_en) n_wr++;
            if (c < 7) @(negedge clk);
        end
        chk("held_done_count", n_done, 1);
        chk("held_write_count", n_wr, 1);
        chk("held_idle_busy", int'(busy), 0);
        chk("held_idle_w_addr", int'(w_addr), 2);
        @(negedge clk);
        chk("held_restart_busy", int'(busy), 1);
        chk("held_restart_w_addr", int'(w_addr), 0);
        chk("held_restart_cfg_idx", int'(cfg_idx), 1);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("held_second_done", int'(seen), 1);
        chk("held_second_result", int'(ram[128]), 26);
        @(negedge clk);
        chk("held_final_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
